instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage + IF/ID pipeline register: drives the instruction-memory request
//  handshake, holds the PC, and delivers each instruction and its opcode field
//  [31:21] to the main control decoder in ID. Handles stall (hazard unit),
//  branch redirect/flush and memory back-pressure; bubbles present opcode 11'b0
//  so the decoder emits all-zero controls.
// PARAMETERS
//  AW        64     PC / instruction-address width
//  RESET_PC  0      PC value loaded on reset (bits [1:0] must be 0)
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request valid
//  imem_addr      out  AW  fetch address (= PC), word aligned
//  imem_ready     in   1   memory accepts req and returns data this cycle
//  imem_rdata     in   32  instruction word, valid when imem_req&imem_ready
//  stall          in   1   hold IF/ID contents and PC
//  branch_taken   in   1   redirect fetch to branch_target, flush IF/ID
//  branch_target  in   AW  redirect address; bits [1:0] forced to 0
//  id_valid       out  1   IF/ID holds a real instruction
//  id_instr       out  32  IF/ID instruction (32'b0 when !id_valid)
//  id_opcode      out  11  id_instr[31:21], to control decoder
//  id_pc          out  AW  address of id_instr
//  id_pc_plus4    out  AW  id_pc + 4 (BL link value), mod 2^AW
// BEHAVIOUR
//  - Reset: state IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_instr=0,
//    id_opcode=0, id_pc=0, id_pc_plus4=0, skid empty. Reset wins mid-transfer.
//  - Handshake: transfer when imem_req&imem_ready same cycle. While req=1 and
//    no transfer, imem_addr must not change. imem_addr = pc always.
//  - States: IDLE, FETCH, HOLD, DROP.
//  - IDLE: req=0; -> FETCH next cycle.
//  - FETCH: req=1.
//    * transfer & !stall: IF/ID <= {rdata, pc}, id_valid=1, pc<=pc+4; stay.
//    * transfer & stall: rdata+pc into 1-entry skid, IF/ID held -> HOLD.
//    * no transfer & !stall: IF/ID <= bubble (id_valid=0, instr=0).
//    * no transfer & stall: IF/ID held.
//  - HOLD: req=0, IF/ID held; when !stall: IF/ID <= skid, pc<=pc+4, skid
//    cleared -> FETCH.
//  - branch_taken (priority over stall, any state): IF/ID <= bubble, skid
//    cleared, pc<=branch_target&~3. If FETCH with req pending and no transfer
//    this cycle -> DROP; else -> FETCH.
//  - DROP: req=1 at old addr until imem_ready; returned data discarded, IF/ID
//    stays bubble; then -> FETCH at redirected pc. Further branch_taken in
//    DROP overwrites pc, stays DROP.
//  - Fetch latency: transfer in cycle N -> id_valid/id_instr visible N+1.
//  - pc+4 wraps modulo 2^AW; id_opcode always equals id_instr[31:21].
// TESTING
//  1 reset, imem_ready=1, rdata=0x8B020020,0xCB030041 -> imem_addr 0,4,8;
//    id_opcode 11'h458 then 11'h658, id_pc 0 then 4, id_pc_plus4 4 then 8.
//  2 stall=1 on transfer of addr 8 for 3 cycles -> req=0, IF/ID/pc frozen;
//    stall=0 -> id_pc=8 next cycle, then imem_addr=0xC.
//  3 branch_taken=1, target=0x103, with stall=1 -> next cycle id_valid=0,
//    id_opcode=0, imem_addr=0x100; stall ignored.
//  4 imem_ready=0 at addr 0x20, branch_taken target 0x40 -> addr held 0x20 until
//    ready; that rdata dropped (id_valid=0); next request addr 0x40.
//  5 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, ready=1 -> first id_pc_plus4=0, next
//    imem_addr=0 (wrap).
//  6 reset asserted in HOLD with valid skid -> next cycle all outputs at reset
//    values, imem_req=0, then fetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage plus the IF/ID pipeline register. Issues word-aligned requests
//   to instruction memory. Holds the PC. Delivers each fetched instruction,
//   its opcode field [31:21], its PC and PC+4 to the decode stage.
//   Handles three conditions:
//     - hazard stall
//     - branch redirect and flush
//     - memory back-pressure
//   A bubble presents id_instr = 0 and id_opcode = 0, so the decoder emits
//   all-zero controls.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   imem_req/addr          fetch request and word address
//   imem_ready/rdata       memory accept and data for a transfer; a transfer
//                          happens only when imem_ready and imem_req are both high
//   stall                  hold IF/ID and PC
//   branch_taken/target    redirect fetch and flush IF/ID; beats stall
//   id_valid/instr/opcode  IF/ID contents to decode
//   id_pc/id_pc_plus4      address of id_instr and its link value
module instr_fetch_unit #(
  parameter int             AW       = 64,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic          id_valid,
  output logic [31:0]   id_instr,
  output logic [10:0]   id_opcode,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc_plus4
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  typedef struct packed {
    logic          vld;
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic          vld;
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } skid_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] drop_addr_q, drop_addr_d;
  ifid_t         ifid_q, ifid_d;
  skid_t         skid_q, skid_d;

  logic [AW-1:0] tgt;
  logic [AW-1:0] pc_inc;

  // Redirect address is forced to word alignment.
  assign tgt    = branch_target & ~AW'(3);
  assign pc_inc = pc_q + AW'(4);   // wraps modulo 2^AW

  // ---------------------------------------------------------------------------
  // State and pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      ifid_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      ifid_q      <= ifid_d;
      skid_q      <= skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, next register contents and request outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    ifid_d      = ifid_q;
    skid_d      = skid_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (branch_taken) begin
          ifid_d.vld   = 1'b0;
          ifid_d.instr = '0;
          pc_d         = tgt;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          ifid_d.vld   = 1'b0;
          ifid_d.instr = '0;
          skid_d       = '0;
          pc_d         = tgt;
          // The request at the old address is still pending.
          // It must complete at that same address, then be thrown away.
          if (!imem_ready) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ready && !stall) begin
          ifid_d.vld   = 1'b1;
          ifid_d.instr = imem_rdata;
          ifid_d.pc    = pc_q;
          ifid_d.pc4   = pc_inc;
          pc_d         = pc_inc;
        end else if (imem_ready) begin
          // Data arrived while decode is stalled.
          // Park it and stop requesting until decode frees up.
          skid_d.vld   = 1'b1;
          skid_d.instr = imem_rdata;
          skid_d.pc    = pc_q;
          state_d      = S_HOLD;
        end else if (!stall) begin
          ifid_d.vld   = 1'b0;
          ifid_d.instr = '0;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          ifid_d.vld   = 1'b0;
          ifid_d.instr = '0;
          skid_d       = '0;
          pc_d         = tgt;
          state_d      = S_FETCH;
        end else if (!stall) begin
          ifid_d.vld   = skid_q.vld;
          ifid_d.instr = skid_q.instr;
          ifid_d.pc    = skid_q.pc;
          ifid_d.pc4   = skid_q.pc + AW'(4);
          pc_d         = pc_inc;
          skid_d       = '0;
          state_d      = S_FETCH;
        end
      end

      S_DROP: begin
        // The old address is held until memory accepts it.
        imem_req     = 1'b1;
        imem_addr    = drop_addr_q;
        ifid_d.vld   = 1'b0;
        ifid_d.instr = '0;
        if (branch_taken) pc_d = tgt;
        if (imem_ready)   state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign id_valid    = ifid_q.vld;
  assign id_instr    = ifid_q.instr;
  assign id_opcode   = ifid_q.instr[31:21];
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus4 = ifid_q.pc4;

endmodule
